sr_req_arbiter: RTL

SR_REQ_ARBITER -- requirements
Module: sr_req_arbiter

---
 rtl/sr_req_arbiter_if.sv | 25 ++
 rtl/sr_req_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sr_req_arbiter_if.sv
// Request/grant and SR flip-flop drive bundle for sr_req_arbiter.
// master: requester side plus the flip-flop feedback; slave: the arbiter.
interface sr_req_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] op;
   logic [NREQ-1:0] gnt;
   logic            s;
   logic            r;
   logic            q_in;
   logic            busy;
   logic            done;
   logic            err;

   modport master (
      output req, op, q_in,
      input  gnt, s, r, busy, done, err
   );

   modport slave (
      input  req, op, q_in,
      output gnt, s, r, busy, done, err
   );
endinterface

// File: rtl/sr_req_arbiter.sv
// Round-robin arbiter sharing one clocked SR flip-flop between NREQ requesters.
// Each grant drives s (op=1) or r (op=0) for HOLD_CYC cycles, then completes.
// Optional macro SR_ARB_VERIFY_EN adds a CHECK state that compares q_in with
// the requested value and pulses err alongside done on a miscompare.
module sr_req_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned HOLD_CYC = 1
) (
   input logic             clk,
   input logic             rst_n,
   sr_req_arbiter_if.slave bus
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = 4;

`ifdef SR_ARB_VERIFY_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1
   } state_t;
`endif

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt;
   logic [NREQ-1:0] r_gnt;
   logic            r_s;
   logic            r_r;
   logic            r_busy;
   logic            r_done;
`ifdef SR_ARB_VERIFY_EN
   logic            r_err;
   logic            r_op_l;
`else
   logic            w_unused_q;
`endif

   logic            w_found;
   logic [PW-1:0]   w_idx;
   logic [PW-1:0]   w_next_ptr;
   logic [NREQ-1:0] w_onehot;

   // Round-robin search: first pending requester at or after r_ptr.
   always_comb begin
      int unsigned v_i;
      w_found = 1'b0;
      w_idx   = '0;
      v_i     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_i = (32'(r_ptr) + k) % NREQ;
         if (!w_found && bus.req[v_i]) begin
            w_found = 1'b1;
            w_idx   = PW'(v_i);
         end
      end
      w_next_ptr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      w_onehot   = NREQ'(1) << w_idx;
   end

   // Arbitration FSM; all outputs registered, s and r only ever set as complements.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SR_ARB_VERIFY_EN
         r_err   <= 1'b0;
         r_op_l  <= 1'b0;
`endif
      end else begin
         r_gnt  <= '0;
         r_done <= 1'b0;
`ifdef SR_ARB_VERIFY_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt   <= w_onehot;
                  r_s     <= bus.op[w_idx];
                  r_r     <= ~bus.op[w_idx];
`ifdef SR_ARB_VERIFY_EN
                  r_op_l  <= bus.op[w_idx];
`endif
                  r_cnt   <= CW'(HOLD_CYC - 1);
                  r_ptr   <= w_next_ptr;
                  r_busy  <= 1'b1;
                  r_state <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (r_cnt == '0) begin
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
`ifdef SR_ARB_VERIFY_EN
                  r_state <= ST_CHECK;
`else
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`ifdef SR_ARB_VERIFY_EN
            ST_CHECK: begin
               r_done  <= 1'b1;
               r_err   <= (bus.q_in != r_op_l);
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
`endif
            default: begin
               r_s     <= 1'b0;
               r_r     <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt  = r_gnt;
   assign bus.s    = r_s;
   assign bus.r    = r_r;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
`ifdef SR_ARB_VERIFY_EN
   assign bus.err  = r_err;
`else
   assign bus.err  = 1'b0;
   assign w_unused_q = bus.q_in;
`endif

endmodule
